// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage: default widths, ctrl-bundle field
// offsets and the NOP ctrl bundle that marks a bubble.
package pipe_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CTRL_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    // Bit positions of the decoded control signals inside the ctrl bundle
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_ALU_OP_LSB = 5;
    localparam int CTRL_ALU_OP_W   = 3;

    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second storage entry used when PIPE_STAGE_SKID_EN is defined; catches an
// input accepted while the main entry is full and not being drained.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage.sv
// Pipeline register stage with stall/flush and a saturating bubble counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and cut out_ready -> in_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_accept;
    logic              w_pop;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;
    logic [CTRL_W-1:0] w_load_ctrl;

    assign w_pop = r_valid & out_ready & ~stall & ~flush;

`ifdef PIPE_STAGE_SKID_EN
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    // in_ready only looks at stall and the registered skid occupancy
    assign in_ready    = rst & ~stall & ~w_skid_valid;
    assign w_accept    = in_valid & in_ready & ~flush;
    assign w_load      = (w_pop & w_skid_valid) | (w_accept & (~r_valid | out_ready));
    assign w_load_data = w_skid_valid ? w_skid_data : in_data;
    assign w_load_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_load  (w_accept & r_valid & ~out_ready),
        .i_pop   (w_pop & w_skid_valid),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );
`else
    assign in_ready    = rst & ~stall & (~r_valid | out_ready);
    assign w_accept    = in_valid & in_ready & ~flush;
    assign w_load      = w_accept;
    assign w_load_data = in_data;
    assign w_load_ctrl = in_ctrl;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_load_data;
            r_ctrl  <= w_load_ctrl;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
        end else if (!r_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_ctrl   = r_valid ? r_ctrl : CTRL_W'(CTRL_NOP);
    assign bubble_cnt = r_bubble_cnt;

endmodule
